// File: rtl/gj_axis_uart_tx_v2.sv
// gj_axis_uart_tx_v2: AXI-Stream fed, FIFO-buffered UART transmitter with configurable
// width, parity, stop bits, bit-period divider and inter-byte / inter-frame idle gaps.
module gj_axis_uart_tx_v2 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_en,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic [15:0]                   byte_gap,
    input  logic [15:0]                   frame_gap,
    input  logic                          tx_tvalid,
    output logic                          tx_tready,
    input  logic [DATA_W-1:0]             tx_tdata,
    input  logic                          tx_tlast,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          byte_done,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, GAP = 3'd5;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W:0]   head;
    logic [2:0]        state;
    logic [DIV_W-1:0]  timer, div_l;
    logic [3:0]        bit_idx;
    logic [15:0]       gap_cnt, gap_l;
    logic [1:0]        pmode_l;
    logic              stop2_l, last_l, par_l;
    logic [DATA_W-1:0] sh;
    logic              push, pop, pop_ok, bit_end, stop_end, gap_end;

    assign head       = mem[rd_ptr];
    assign tx_tready  = (count != (AW+1)'(FIFO_DEPTH)) && !rst;
    assign push       = tx_tvalid && tx_tready;
    assign pop_ok     = cfg_en && (count != '0);
    assign bit_end    = timer == div_l;
    assign stop_end   = (state == STOP) && bit_end && (bit_idx[0] == stop2_l);
    assign gap_end    = (state == GAP) && bit_end && (gap_cnt == gap_l - 16'd1);
    assign pop        = pop_ok && ((state == IDLE) || (stop_end && gap_l == '0) || gap_end);
    assign byte_done  = stop_end && !rst;
    assign frame_done = byte_done && last_l;
    assign busy       = state != IDLE;
    assign fifo_level = count;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {tx_tlast, tx_tdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // A pop latches the whole character context so config only changes at boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
        end else if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            timer   <= '0;
            div_l   <= clk_div;
            pmode_l <= parity_mode;
            stop2_l <= stop2;
            last_l  <= head[DATA_W];
            sh      <= head[DATA_W-1:0];
            gap_l   <= head[DATA_W] ? frame_gap : byte_gap;
            par_l   <= parity_mode == 2'b01 ? ~^head[DATA_W-1:0] :
                       parity_mode == 2'b10 ? ^head[DATA_W-1:0] : 1'b1;
        end else if (state != IDLE) begin
            timer <= bit_end ? '0 : timer + 1'b1;
            if (bit_end)
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= sh[0];
                    end
                    DATA: begin
                        if (bit_idx == 4'(DATA_W - 1)) begin
                            state   <= pmode_l != 2'b00 ? PARITY : STOP;
                            tx      <= pmode_l != 2'b00 ? par_l : 1'b1;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            sh      <= sh >> 1;
                            tx      <= sh[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        if (stop_end) begin
                            state   <= gap_l != '0 ? GAP : IDLE;
                            gap_cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_end) state <= IDLE;
                        else gap_cnt <= gap_cnt + 16'd1;
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: doc/gj_axis_uart_tx_v2.md
# gj_axis_uart_tx_v2

Parametrised UART transmitter that takes an AXI-Stream byte stream into an internal FIFO and serialises it onto `tx`. It is the next-generation transmit path of the gjAxisUart family. Over the first-generation transmitter it adds:
- configurable data width, parity mode and stop bits;
- a built-in bit-period divider;
- a buffered input;
- separate inter-byte and inter-frame idle gaps, where a frame ends at `tx_tlast`.

The register block drives all configuration inputs.

## Interface
- `DATA_W`, 8: data bits per character. Legal range 5..9.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2, ≥2.
- `DIV_W`, 16: width of `clk_div`.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_en` in 1: 1 = transmitter may start new characters.
- `clk_div` in DIV_W: bit period is `clk_div`+1 clk cycles.
- `parity_mode` in 2: 00 none, 01 odd, 10 even, 11 mark (parity bit = 1).
- `stop2` in 1: 0 = 1 stop bit, 1 = 2 stop bits.
- `byte_gap` in 16: idle bit-times inserted after a non-last character.
- `frame_gap` in 16: idle bit-times inserted after a `tlast` character; replaces `byte_gap`.
- `tx_tvalid` in 1, `tx_tready` out 1, `tx_tdata` in DATA_W, `tx_tlast` in 1: AXI-Stream input.
- `tx` out 1: serial line; idle level is 1.
- `busy` out 1: 1 while not in IDLE.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `byte_done` out 1: one-cycle pulse at the last cycle of a character's final stop bit.
- `frame_done` out 1: same as `byte_done`, but only for a `tlast` character.

## Operation
- **FIFO**
  - Each entry is {tlast, data}.
  - Push when `tx_tvalid & tx_tready`.
  - `tx_tready` = !full & !rst. It is combinational, with no pass-through: a full FIFO refuses a push even in a cycle where it pops.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves `fifo_level` unchanged.
- **Pop and latch**
  - Pop condition: the FSM is in IDLE, or at the end of STOP with gap 0, or at the end of GAP; and `cfg_en`=1; and the FIFO is non-empty.
  - On a pop, `clk_div`, `parity_mode`, `stop2`, the applicable gap value, data and tlast are all latched.
  - Configuration changes therefore take effect only at character boundaries.
- **FSM states**
  - IDLE: `tx`=1. On a pop → START.
  - START: `tx`=0 for one bit → DATA.
  - DATA: sends `DATA_W` bits, LSB first → PARITY if `parity_mode`≠00, else → STOP.
  - PARITY: sends one bit:
    - odd: XOR of the data bits, inverted;
    - even: XOR of the data bits;
    - mark: 1.
    → STOP.
  - STOP: `tx`=1 for 1 or 2 bits, then pulse `byte_done` (and `frame_done` if tlast).
    - If the latched gap > 0 → GAP.
    - Else, if a pop is possible → START.
    - Else → IDLE.
  - GAP: `tx`=1 for gap×(`clk_div`+1) cycles. Then → START on a pop, else → IDLE.
- **Bit timer**
  - A counter of width DIV_W counts 0..`clk_div` and reloads to 0 on every bit boundary and on entry to START.
  - A bit index counter tracks DATA and STOP bits.
  - A 16-bit gap counter counts idle bit-times.
- **`cfg_en` cleared mid-character:** the current character and its gap complete normally. No further pop occurs, and the FSM ends in IDLE.
- **Reset:** the FIFO is flushed and the FSM returns to IDLE. Reset values:
  - `tx`=1;
  - `busy`=0;
  - `fifo_level`=0;
  - `byte_done`=`frame_done`=0;
  - `tx_tready`=0 while `rst` is high, and 1 the cycle after.

  Reset mid-character truncates the character immediately: `tx`=1 in the cycle after reset is sampled.

## Timing
- `tx` and `busy` are registered outputs.
- Latency from a push into an empty FIFO while in IDLE:
  - push sampled at cycle t;
  - pop at t+1;
  - `tx` falls at t+2.
- Character length is (1 + DATA_W + P + S)×(`clk_div`+1) cycles, where P ∈ {0,1} (parity bit present) and S ∈ {1,2} (stop bits).
- With gap 0 and data available, the next start bit begins in the cycle immediately after the last stop-bit cycle. There are zero dead cycles.
- `clk_div`=0 gives one clk cycle per bit. Maximum `clk_div` is 2^DIV_W−1, and the timer must not overflow.
- `fifo_level` is updated in the cycle after a push or pop.

## Test plan
- DATA_W=8, `clk_div`=3, parity none, 1 stop bit, single push of 0xA5:
  - `tx`=0 for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - then 1 for 4 cycles;
  - `byte_done` pulses on the 40th cycle after `tx` falls.
- `parity_mode`=10, send 0x07 → parity bit 1. `parity_mode`=01, send 0x07 → parity bit 0. `stop2`=1 → stop level held for 8 cycles.
- `cfg_en`=0, push 17 bytes → first 16 accepted, `fifo_level`=16, `tx_tready`=0, `tx` stays 1. Then set `cfg_en`=1 → 16 characters sent back-to-back with no dead cycles, and `fifo_level` returns to 0.
- `clk_div`=0, `byte_gap`=2, `frame_gap`=5, 3-byte frame with tlast on byte 3 followed by a second frame → 2 idle cycles after bytes 1 and 2, 5 idle cycles after byte 3; `frame_done` pulses only for byte 3.
- Assert `rst` during the DATA state of the 2nd of 4 queued bytes → next cycle `tx`=1, `busy`=0, `fifo_level`=0. Nothing further is transmitted without a new push.
- DATA_W=5 and DATA_W=9 builds: send 0x15 and 0x1A5 respectively → exactly 5 or 9 data bits, LSB first.
